// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a dual-port data RAM (A = write, B = read) between the
// core load/store stage (req0) and the loader/DMA port (req1). One write and
// one read may issue per cycle; each read is tagged with its requester id so
// that the data can be routed back after the fixed RAM read latency.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W/8-1:0] req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W/8-1:0] req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic [ADDR_W-1:0]   mem_addra,
  output logic [DATA_W/8-1:0] mem_wea,
  output logic [DATA_W-1:0]   mem_dina,
  output logic [ADDR_W-1:0]   mem_addrb,
  input  logic [DATA_W-1:0]   mem_doutb
);

  localparam int BE_W     = DATA_W / 8;
  localparam int WORD_LSB = $clog2(BE_W);
  localparam int WC_W     = $clog2(MAX_WAIT + 1);

  // Request classification and grant decisions
  logic              wr0, rd0, wr1, rd1;
  logic              prefer1;
  logic              gnt_wr0, gnt_wr1, gnt_rd0, gnt_rd1;
  logic              hazard, issue_ok;
  logic              wr_issue, rd_issue;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [BE_W-1:0]   wr_we;
  logic [DATA_W-1:0] wr_wdata;

  // Starvation counter for req1
  logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;

  // Registered RAM-side outputs
  logic [ADDR_W-1:0] mem_addra_reg, mem_addrb_reg;
  logic [BE_W-1:0]   mem_wea_reg;
  logic [DATA_W-1:0] mem_dina_reg;

  // Read tag pipe: bit 0 is the issue stage, bit READ_LAT is the response stage
  logic [READ_LAT:0] tag_v_reg, tag_id_reg;

  // Port A and port B are arbitrated independently; a read that hits the word
  // being written this cycle is deferred so the RAM never sees a same-cycle
  // read/write collision on one word.
  always_comb begin
    wr0      = req0_valid & (|req0_we);
    rd0      = req0_valid & ~(|req0_we);
    wr1      = req1_valid & (|req1_we);
    rd1      = req1_valid & ~(|req1_we);
    prefer1  = (wait_cnt_reg == WC_W'(MAX_WAIT));
    gnt_wr0  = wr0 & (~wr1 | ~prefer1);
    gnt_wr1  = wr1 & (~wr0 | prefer1);
    gnt_rd0  = rd0 & (~rd1 | ~prefer1);
    gnt_rd1  = rd1 & (~rd0 | prefer1);
    wr_addr  = gnt_wr1 ? req1_addr  : req0_addr;
    wr_we    = gnt_wr1 ? req1_we    : req0_we;
    wr_wdata = gnt_wr1 ? req1_wdata : req0_wdata;
    rd_addr  = gnt_rd1 ? req1_addr  : req0_addr;
    hazard   = (gnt_wr0 | gnt_wr1) & (gnt_rd0 | gnt_rd1) &
               (wr_addr[ADDR_W-1:WORD_LSB] == rd_addr[ADDR_W-1:WORD_LSB]);
    issue_ok = ~rst & ~hold;
    wr_issue = issue_ok & (gnt_wr0 | gnt_wr1);
    rd_issue = issue_ok & (gnt_rd0 | gnt_rd1) & ~hazard;
    req0_ready = issue_ok & (gnt_wr0 | (gnt_rd0 & ~hazard));
    req1_ready = issue_ok & (gnt_wr1 | (gnt_rd1 & ~hazard));
  end

  // req1 starvation count: frozen under hold, cleared on grant or idle, saturating
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!hold) begin
      if (!req1_valid || req1_ready) begin
        wait_cnt_next = '0;
      end else if (wait_cnt_reg != WC_W'(MAX_WAIT)) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end
  end

  // Register RAM commands, the starvation counter and the read tag pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wea_reg   <= '0;
      mem_addra_reg <= '0;
      mem_dina_reg  <= '0;
      mem_addrb_reg <= '0;
      wait_cnt_reg  <= '0;
      tag_v_reg     <= '0;
      tag_id_reg    <= '0;
    end else begin
      mem_wea_reg <= wr_issue ? wr_we : '0;
      if (wr_issue) begin
        mem_addra_reg <= wr_addr;
        mem_dina_reg  <= wr_wdata;
      end
      if (rd_issue) begin
        mem_addrb_reg <= rd_addr;
      end
      wait_cnt_reg <= wait_cnt_next;
      tag_v_reg    <= {tag_v_reg[READ_LAT-1:0], rd_issue};
      tag_id_reg   <= {tag_id_reg[READ_LAT-1:0], gnt_rd1};
    end
  end

  assign mem_addra = mem_addra_reg;
  assign mem_wea   = mem_wea_reg;
  assign mem_dina  = mem_dina_reg;
  assign mem_addrb = mem_addrb_reg;

  // Per-requester response path
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      localparam logic RSP_ID = 1'(gi);
      logic [DATA_W-1:0] rdata_reg;
      logic              valid;

      // Capture RAM data on the edge this requester's tag enters the response stage
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (tag_v_reg[READ_LAT-1] && (tag_id_reg[READ_LAT-1] == RSP_ID)) begin
          rdata_reg <= mem_doutb;
        end
      end

      assign valid = tag_v_reg[READ_LAT] & (tag_id_reg[READ_LAT] == RSP_ID);
    end
  endgenerate

  assign rsp0_valid = g_rsp[0].valid;
  assign rsp0_rdata = g_rsp[0].rdata_reg;
  assign rsp1_valid = g_rsp[1].valid;
  assign rsp1_rdata = g_rsp[1].rdata_reg;

endmodule
